mc_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath (PC, IM/IR, RF, EXT, ALU, DM).

---
 rtl/mc_ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: IF/ID/EXE/MEM/WB stepping, datapath strobes and selects,
// DM ready handshake with timeout, retired-instruction counter and sticky fault.
module mc_ctrl_fsm #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_rdy,
   output logic             pc_wr,
   output logic             ir_wr,
   output logic             rf_wr,
   output logic             dm_wr,
   output logic             dm_rd,
   output logic             reg_dst,
   output logic             mem2reg,
   output logic             alu_src,
   output logic [1:0]       ext_op,
   output logic [1:0]       alu_op,
   output logic [1:0]       npc_op,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             fault
);

   typedef enum logic [2:0] {
      S_IF    = 3'd0,
      S_ID    = 3'd1,
      S_EXE   = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_FAULT = 3'd7
   } state_t;

   localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

   state_t           state_q;
   logic [7:0]       wait_q;
   logic [CNT_W-1:0] retired_q;
   logic             fault_q;

   logic       is_r, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;
   logic [1:0] r_alu_op;
   logic       mem_timeout;

   always_comb begin
      is_r     = 1'b0;
      is_ori   = 1'b0;
      is_lui   = 1'b0;
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      is_beq   = 1'b0;
      is_j     = 1'b0;
      r_alu_op = 2'b00;
      case (opcode)
         6'b000000: begin
            is_r = 1'b1;
            case (funct)
               6'b100001: r_alu_op = 2'b00;
               6'b100011: r_alu_op = 2'b01;
               6'b100100: r_alu_op = 2'b10;
               6'b100101: r_alu_op = 2'b11;
               default:   is_r     = 1'b0;
            endcase
         end
         6'b001101: is_ori = 1'b1;
         6'b001111: is_lui = 1'b1;
         6'b100011: is_lw  = 1'b1;
         6'b101011: is_sw  = 1'b1;
         6'b000100: is_beq = 1'b1;
         6'b000010: is_j   = 1'b1;
         default: ;
      endcase
      legal = is_r | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;
   end

   // Timeout fires on the MEM cycle after WAIT_LIMIT stalled cycles, unless ready arrives then.
   assign mem_timeout = (state_q == S_MEM) && !mem_rdy && (wait_q == WAIT_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IF;
         wait_q    <= '0;
         retired_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IF: state_q <= S_ID;
            S_ID: begin
               if (is_j) begin
                  state_q   <= S_IF;
                  retired_q <= retired_q + CNT_W'(1);
               end else if (!legal) begin
                  state_q <= S_FAULT;
                  fault_q <= 1'b1;
               end else begin
                  state_q <= S_EXE;
               end
            end
            S_EXE: begin
               if (is_beq) begin
                  state_q   <= S_IF;
                  retired_q <= retired_q + CNT_W'(1);
               end else if (is_lw || is_sw) begin
                  state_q <= S_MEM;
                  wait_q  <= '0;
               end else begin
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (mem_rdy) begin
                  if (is_sw) begin
                     state_q   <= S_IF;
                     retired_q <= retired_q + CNT_W'(1);
                  end else begin
                     state_q <= S_WB;
                  end
               end else if (mem_timeout) begin
                  state_q <= S_FAULT;
                  fault_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            S_WB: begin
               state_q   <= S_IF;
               retired_q <= retired_q + CNT_W'(1);
            end
            default: begin
               state_q <= S_FAULT;
               fault_q <= 1'b1;
            end
         endcase
      end
   end

   // Outputs are gated by rst so strobes drop the moment reset asserts, not at the next edge.
   always_comb begin
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      rf_wr   = 1'b0;
      dm_wr   = 1'b0;
      dm_rd   = 1'b0;
      reg_dst = 1'b0;
      mem2reg = 1'b0;
      alu_src = 1'b0;
      ext_op  = 2'b00;
      alu_op  = 2'b00;
      npc_op  = 2'b00;
      if (rst) begin
         case (state_q)
            S_IF: begin
               ir_wr = 1'b1;
               pc_wr = 1'b1;
            end
            S_ID: begin
               if (is_j) begin
                  pc_wr  = 1'b1;
                  npc_op = 2'b10;
               end
            end
            S_EXE, S_WB: begin
               if (is_r) begin
                  alu_op = r_alu_op;
               end else if (is_ori || is_lui) begin
                  alu_src = 1'b1;
                  ext_op  = is_lui ? 2'b10 : 2'b00;
                  alu_op  = 2'b11;
                  reg_dst = 1'b1;
               end else if (is_lw || is_sw) begin
                  alu_src = 1'b1;
                  ext_op  = 2'b01;
                  reg_dst = (state_q == S_WB);
                  mem2reg = (state_q == S_WB);
               end else if (is_beq && state_q == S_EXE) begin
                  alu_op = 2'b01;
                  ext_op = 2'b01;
                  npc_op = 2'b01;
                  pc_wr  = zero;
               end
               rf_wr = (state_q == S_WB);
            end
            S_MEM: begin
               if (!mem_timeout) begin
                  alu_src = 1'b1;
                  ext_op  = 2'b01;
                  dm_rd   = is_lw;
                  dm_wr   = is_sw;
               end
            end
            default: ;
         endcase
      end
   end

   assign state   = 3'(state_q);
   assign retired = retired_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle state/strobe checks for each instruction class,
// reset mid-MEM, stall, timeout and illegal-opcode faults, and counter wrap on a narrow instance.
module tb_mc_ctrl_fsm;

   logic        clk, rst, zero, mem_rdy;
   logic [5:0]  opcode, funct;
   logic        pc_wr, ir_wr, rf_wr, dm_wr, dm_rd, reg_dst, mem2reg, alu_src, fault;
   logic [1:0]  ext_op, alu_op, npc_op;
   logic [2:0]  st;
   logic [31:0] retired;

   logic        d2_pc_wr, d2_ir_wr, d2_rf_wr, d2_dm_wr, d2_dm_rd, d2_reg_dst, d2_mem2reg;
   logic        d2_alu_src, d2_fault;
   logic [1:0]  d2_ext_op, d2_alu_op, d2_npc_op;
   logic [2:0]  d2_state;
   logic [1:0]  d2_retired;

   int unsigned checks = 0;
   int unsigned errors = 0;

   localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

   mc_ctrl_fsm #(.CNT_W(32), .WAIT_LIMIT(15)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
      .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr), .dm_wr(dm_wr), .dm_rd(dm_rd),
      .reg_dst(reg_dst), .mem2reg(mem2reg), .alu_src(alu_src), .ext_op(ext_op),
      .alu_op(alu_op), .npc_op(npc_op), .state(st), .retired(retired), .fault(fault)
   );

   mc_ctrl_fsm #(.CNT_W(2), .WAIT_LIMIT(15)) dut_narrow (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
      .pc_wr(d2_pc_wr), .ir_wr(d2_ir_wr), .rf_wr(d2_rf_wr), .dm_wr(d2_dm_wr), .dm_rd(d2_dm_rd),
      .reg_dst(d2_reg_dst), .mem2reg(d2_mem2reg), .alu_src(d2_alu_src), .ext_op(d2_ext_op),
      .alu_op(d2_alu_op), .npc_op(d2_npc_op), .state(d2_state), .retired(d2_retired),
      .fault(d2_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [13:0] outs;
   assign outs = {pc_wr, ir_wr, rf_wr, dm_wr, dm_rd, reg_dst, mem2reg, alu_src,
                  ext_op, alu_op, npc_op};

   function automatic logic [13:0] mk(input logic pc, ir, rf, dw, dr, rd, m2r, as,
                                      input logic [1:0] ext, alu, npc);
      return {pc, ir, rf, dw, dr, rd, m2r, as, ext, alu, npc};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [2:0] exp_st, input logic [13:0] exp_outs);
      chk({tag, ".state"}, {29'd0, st}, {29'd0, exp_st});
      chk({tag, ".outs"}, {18'd0, outs}, {18'd0, exp_outs});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [13:0] o_if, o_j, o_addr, o_lwmem, o_swmem, o_lwwb, o_rwb;
      logic [13:0] o_ori_exe, o_ori_wb, o_lui_exe, o_beq1, o_beq0;
      o_if      = mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
      o_j       = mk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
      o_addr    = mk(0,0,0,0,0,0,0,1,2'b01,2'b00,2'b00);
      o_lwmem   = mk(0,0,0,0,1,0,0,1,2'b01,2'b00,2'b00);
      o_swmem   = mk(0,0,0,1,0,0,0,1,2'b01,2'b00,2'b00);
      o_lwwb    = mk(0,0,1,0,0,1,1,1,2'b01,2'b00,2'b00);
      o_rwb     = mk(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
      o_ori_exe = mk(0,0,0,0,0,1,0,1,2'b00,2'b11,2'b00);
      o_ori_wb  = mk(0,0,1,0,0,1,0,1,2'b00,2'b11,2'b00);
      o_lui_exe = mk(0,0,0,0,0,1,0,1,2'b10,2'b11,2'b00);
      o_beq1    = mk(1,0,0,0,0,0,0,0,2'b01,2'b01,2'b01);
      o_beq0    = mk(0,0,0,0,0,0,0,0,2'b01,2'b01,2'b01);

      rst = 1'b0; opcode = OP_R; funct = 6'd0; zero = 1'b0; mem_rdy = 1'b0;
      tick; tick;
      cyc("reset", 3'd0, 14'd0);
      chk("reset.retired", retired, 32'd0);
      chk("reset.fault", {31'd0, fault}, 32'd0);

      // addu: IF, ID, EXE, WB
      rst = 1'b1; funct = 6'b100001; #1;
      cyc("addu.IF", 3'd0, o_if);
      tick; cyc("addu.ID", 3'd1, 14'd0);
      tick; cyc("addu.EXE", 3'd2, 14'd0);
      tick; cyc("addu.WB", 3'd4, o_rwb);
      chk("addu.WB.retired", retired, 32'd0);
      tick; cyc("addu.next", 3'd0, o_if);
      chk("addu.retired", retired, 32'd1);

      // three jumps: 2 cycles each; the 2-bit counter wraps 3 -> 0
      opcode = OP_J; #1;
      for (int i = 0; i < 3; i++) begin
         tick; cyc("j.ID", 3'd1, o_j);
         tick; cyc("j.next", 3'd0, o_if);
         chk("j.retired", retired, 32'(i + 2));
      end
      chk("wrap.narrow", {30'd0, d2_retired}, 32'd0);

      // lw with three stall cycles
      opcode = OP_LW; mem_rdy = 1'b0; #1;
      tick; cyc("lw.ID", 3'd1, 14'd0);
      tick; cyc("lw.EXE", 3'd2, o_addr);
      for (int i = 0; i < 3; i++) begin
         tick; cyc("lw.MEMstall", 3'd3, o_lwmem);
      end
      tick; mem_rdy = 1'b1; #1; cyc("lw.MEMrdy", 3'd3, o_lwmem);
      tick; mem_rdy = 1'b0; #1; cyc("lw.WB", 3'd4, o_lwwb);
      chk("lw.WB.retired", retired, 32'd4);
      tick; cyc("lw.next", 3'd0, o_if);
      chk("lw.retired", retired, 32'd5);

      // reset asserted while lw waits in MEM
      tick; tick; tick; cyc("lw2.MEM", 3'd3, o_lwmem);
      rst = 1'b0; #1; cyc("rst.async", 3'd0, 14'd0);
      tick; cyc("rst.held", 3'd0, 14'd0);
      chk("rst.retired", retired, 32'd0);
      chk("rst.fault", {31'd0, fault}, 32'd0);
      rst = 1'b1; #1; cyc("rst.release", 3'd0, o_if);

      // ori, lui
      opcode = OP_ORI; #1;
      tick; cyc("ori.ID", 3'd1, 14'd0);
      tick; cyc("ori.EXE", 3'd2, o_ori_exe);
      tick; cyc("ori.WB", 3'd4, o_ori_wb);
      tick; chk("ori.retired", retired, 32'd1);
      opcode = OP_LUI; #1;
      tick; tick; cyc("lui.EXE", 3'd2, o_lui_exe);
      tick; tick; cyc("lui.next", 3'd0, o_if);
      chk("lui.retired", retired, 32'd2);

      // beq taken, then not taken
      opcode = OP_BEQ; zero = 1'b1; #1;
      tick; cyc("beq1.ID", 3'd1, 14'd0);
      tick; cyc("beq1.EXE", 3'd2, o_beq1);
      tick; cyc("beq1.next", 3'd0, o_if);
      chk("beq1.retired", retired, 32'd3);
      zero = 1'b0; #1;
      tick; tick; cyc("beq0.EXE", 3'd2, o_beq0);
      tick; cyc("beq0.next", 3'd0, o_if);
      chk("beq0.retired", retired, 32'd4);

      // sw with mem_rdy stuck low: 15 stalled cycles, then timeout cycle, then FAULT
      opcode = OP_SW; #1;
      tick; tick; cyc("sw.EXE", 3'd2, o_addr);
      for (int i = 0; i < 15; i++) begin
         tick; cyc("sw.MEMstall", 3'd3, o_swmem);
      end
      tick; cyc("sw.timeout", 3'd3, 14'd0);
      tick; cyc("sw.FAULT", 3'd7, 14'd0);
      chk("sw.fault", {31'd0, fault}, 32'd1);
      chk("sw.retired", retired, 32'd4);
      tick; tick; tick; cyc("sw.FAULT.hold", 3'd7, 14'd0);
      chk("sw.narrow.retired", {30'd0, d2_retired}, 32'd0);

      // illegal opcode after a clean reset
      rst = 1'b0; #1; tick;
      chk("rst2.fault", {31'd0, fault}, 32'd0);
      rst = 1'b1; opcode = OP_BAD; #1;
      tick; cyc("bad.ID", 3'd1, 14'd0);
      tick; cyc("bad.FAULT", 3'd7, 14'd0);
      chk("bad.fault", {31'd0, fault}, 32'd1);
      opcode = OP_LW; mem_rdy = 1'b1; #1;
      tick; tick; cyc("bad.FAULT.hold", 3'd7, 14'd0);
      chk("bad.retired", retired, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
